// File: rtl/cnn_core_scheduler_if.sv
// Job-in / result-out streams and core-array control for cnn_core_scheduler.
// slave = scheduler side, master = host/DMA plus core-array side.
interface cnn_core_scheduler_if #(
  parameter int N_CORES = 4,
  parameter int ID_W    = 8,
  parameter int RES_W   = 32,
  parameter int CSEL_W  = $clog2(N_CORES)
);
  logic                     job_valid;
  logic [ID_W-1:0]          job_id;
  logic                     job_ready;
  logic [CSEL_W-1:0]        core_sel;
  logic [N_CORES-1:0]       core_start;
  logic [N_CORES-1:0]       core_done;
  logic [N_CORES*RES_W-1:0] core_value;
  logic                     res_valid;
  logic                     res_ready;
  logic [ID_W-1:0]          res_id;
  logic [CSEL_W-1:0]        res_core;
  logic [RES_W-1:0]         res_value;
  logic [N_CORES-1:0]       core_busy;
  logic                     idle;
  logic                     err_spurious;

  modport slave (
    input  job_valid, job_id, core_done, core_value, res_ready,
    output job_ready, core_sel, core_start, res_valid, res_id, res_core, res_value,
           core_busy, idle, err_spurious
  );

  modport master (
    output job_valid, job_id, core_done, core_value, res_ready,
    input  job_ready, core_sel, core_start, res_valid, res_id, res_core, res_value,
           core_busy, idle, err_spurious
  );
endinterface

// File: rtl/cnn_core_scheduler.sv
// Dispatches tagged jobs to the lowest free core (start pulse 1 cycle after accept) and returns
// results round-robin 1 cycle after done; a stalled result holds its grant until popped.
module cnn_core_scheduler #(
  parameter int N_CORES = 4,
  parameter int ID_W    = 8,
  parameter int RES_W   = 32,
  parameter int CSEL_W  = $clog2(N_CORES)
) (
  input logic                  clk,
  input logic                  rst,
  cnn_core_scheduler_if.slave  bus
);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;
  localparam logic [CSEL_W:0]   N_EXT  = (CSEL_W+1)'(N_CORES);
  localparam logic [CSEL_W-1:0] LAST_C = CSEL_W'(N_CORES - 1);

  logic [1:0]         state_q [N_CORES];
  logic [ID_W-1:0]    tag_q   [N_CORES];
  logic [RES_W-1:0]   value_q [N_CORES];
  logic [CSEL_W-1:0]  rr_ptr_q;
  logic [CSEL_W-1:0]  hold_idx_q;
  logic               hold_vld_q;
  logic [CSEL_W-1:0]  core_sel_q;
  logic [N_CORES-1:0] start_q;
  logic               err_q;

  logic [N_CORES-1:0] free_vec;
  logic [N_CORES-1:0] pend_vec;
  logic [CSEL_W-1:0]  free_idx;
  logic [CSEL_W-1:0]  rr_idx;
  logic               rr_found;
  logic [CSEL_W:0]    cand;
  logic [CSEL_W-1:0]  gnt_idx;
  logic [CSEL_W-1:0]  rr_next;
  logic               any_free;
  logic               res_vld;
  logic               accept;
  logic               pop;

  always_comb begin
    free_vec = '0;
    pend_vec = '0;
    for (int k = 0; k < N_CORES; k++) begin
      free_vec[k] = (state_q[k] == S_FREE);
      pend_vec[k] = (state_q[k] == S_PEND);
    end
  end

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (free_vec[k]) free_idx = CSEL_W'(k);
    end
  end

  always_comb begin
    rr_idx   = rr_ptr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_CORES; i++) begin
      cand = {1'b0, rr_ptr_q} + (CSEL_W+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!rr_found && pend_vec[cand[CSEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[CSEL_W-1:0];
      end
    end
  end

  // A stalled grant is frozen so cores finishing during backpressure cannot steal it.
  assign gnt_idx  = hold_vld_q ? hold_idx_q : rr_idx;
  assign rr_next  = (gnt_idx == LAST_C) ? '0 : gnt_idx + 1'b1;
  assign any_free = |free_vec;
  assign res_vld  = |pend_vec;
  assign accept   = bus.job_valid && any_free;
  assign pop      = res_vld && bus.res_ready;

  assign bus.job_ready    = any_free;
  assign bus.core_start   = start_q;
  assign bus.core_sel     = core_sel_q;
  assign bus.res_valid    = res_vld;
  assign bus.res_id       = res_vld ? tag_q[gnt_idx]   : '0;
  assign bus.res_core     = res_vld ? gnt_idx          : '0;
  assign bus.res_value    = res_vld ? value_q[gnt_idx] : '0;
  assign bus.core_busy    = ~free_vec;
  assign bus.idle         = (&free_vec) && (start_q == '0);
  assign bus.err_spurious = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CORES; k++) begin
        state_q[k] <= S_FREE;
        tag_q[k]   <= '0;
        value_q[k] <= '0;
      end
      rr_ptr_q   <= '0;
      hold_idx_q <= '0;
      hold_vld_q <= 1'b0;
      core_sel_q <= '0;
      start_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      start_q    <= '0;
      core_sel_q <= '0;
      if (accept) begin
        start_q    <= N_CORES'(1) << free_idx;
        core_sel_q <= free_idx;
      end
      // Accept and pop both act on pre-edge state, so a just-popped core is never reused this cycle.
      for (int k = 0; k < N_CORES; k++) begin
        case (state_q[k])
          S_FREE: begin
            if (accept && (free_idx == CSEL_W'(k))) begin
              state_q[k] <= S_RUN;
              tag_q[k]   <= bus.job_id;
            end
          end
          S_RUN: begin
            if (bus.core_done[k]) begin
              state_q[k] <= S_PEND;
              value_q[k] <= bus.core_value[k*RES_W +: RES_W];
            end
          end
          S_PEND: begin
            if (pop && (gnt_idx == CSEL_W'(k))) state_q[k] <= S_FREE;
          end
          default: state_q[k] <= S_FREE;
        endcase
        if (bus.core_done[k] && (state_q[k] != S_RUN)) err_q <= 1'b1;
      end
      if (pop) rr_ptr_q <= rr_next;
      hold_vld_q <= res_vld && !bus.res_ready;
      if (res_vld && !bus.res_ready) hold_idx_q <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_cnn_core_scheduler.sv
// Directed bench for cnn_core_scheduler: cycle table plus hand-written multi-cycle sequences.
module tb_cnn_core_scheduler;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [7:0] tag_m [N];

  cnn_core_scheduler_if #(.N_CORES(N), .ID_W(8), .RES_W(32)) bus ();

  cnn_core_scheduler #(.N_CORES(N), .ID_W(8), .RES_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        jv;
    logic [7:0]  jid;
    logic [3:0]  done;
    logic [31:0] val;
    logic        rr;
    logic [55:0] exp;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic r, input logic jv, input logic [7:0] jid,
                              input logic [3:0] dn, input logic [31:0] val, input logic rr,
                              input logic jr, input logic [3:0] st, input logic [1:0] sel,
                              input logic rv, input logic [7:0] rid, input logic [1:0] rc,
                              input logic [31:0] rval, input logic [3:0] busy,
                              input logic idl, input logic err);
    vec_t v;
    v.rst  = r;
    v.jv   = jv;
    v.jid  = jid;
    v.done = dn;
    v.val  = val;
    v.rr   = rr;
    v.exp  = {jr, st, sel, rv, rid, rc, rval, busy, idl, err};
    return v;
  endfunction

  function automatic logic [55:0] observe();
    return {bus.job_ready, bus.core_start, bus.core_sel, bus.res_valid, bus.res_id,
            bus.res_core, bus.res_value, bus.core_busy, bus.idle, bus.err_spurious};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic set_values(input logic [31:0] base);
    for (int k = 0; k < N; k++) bus.core_value[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic do_done(input logic [3:0] m, input logic [31:0] base);
    bus.core_done = m;
    set_values(base);
    tick();
    bus.core_done = '0;
  endtask

  task automatic launch(input logic [7:0] id, input int c);
    bus.job_valid = 1'b1;
    bus.job_id    = id;
    tick();
    bus.job_valid = 1'b0;
    chk($sformatf("launch_%0h", id), {bus.core_start, bus.core_sel}, {4'(1 << c), 2'(c)});
    tag_m[c] = id;
  endtask

  task automatic burst(input logic [15:0] ord, input logic [31:0] base);
    logic [1:0] c;
    for (int i = 0; i < 4; i++) begin
      c = 2'(ord[i*4 +: 4]);
      chk($sformatf("burst_%0d", i), {bus.res_valid, bus.res_core, bus.res_id, bus.res_value},
          {1'b1, c, tag_m[c], base + 32'(c)});
      bus.res_ready = 1'b1;
      tick();
    end
    bus.res_ready = 1'b0;
    chk("burst_end", {63'd0, bus.res_valid}, 64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.job_valid  = 1'b0;
    bus.job_id     = '0;
    bus.core_done  = '0;
    bus.core_value = '0;
    bus.res_ready  = 1'b0;
    for (int k = 0; k < N; k++) tag_m[k] = '0;

    //                 rst jv jid    done     val       rr  | jr st       sel rv rid    rc rval       busy     idl err
    vecs[0]  = mk(1, 0, 8'h00, 4'b0000, 32'h0,    0,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0000, 1, 0);
    vecs[1]  = mk(0, 1, 8'h11, 4'b0000, 32'h0,    0,   1, 4'b0001, 0, 0, 8'h00, 0, 32'h0,   4'b0001, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 4'b0000, 32'h0,    0,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0001, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 4'b0001, 32'h7,    0,   1, 4'b0000, 0, 1, 8'h11, 0, 32'h7,   4'b0001, 0, 0);
    vecs[4]  = mk(0, 0, 8'h00, 4'b0000, 32'h0,    1,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0000, 1, 0);
    vecs[5]  = mk(0, 1, 8'hA0, 4'b0000, 32'h0,    0,   1, 4'b0001, 0, 0, 8'h00, 0, 32'h0,   4'b0001, 0, 0);
    vecs[6]  = mk(0, 1, 8'hA1, 4'b0000, 32'h0,    0,   1, 4'b0010, 1, 0, 8'h00, 0, 32'h0,   4'b0011, 0, 0);
    vecs[7]  = mk(0, 1, 8'hA2, 4'b0000, 32'h0,    0,   1, 4'b0100, 2, 0, 8'h00, 0, 32'h0,   4'b0111, 0, 0);
    vecs[8]  = mk(0, 1, 8'hA3, 4'b0000, 32'h0,    0,   0, 4'b1000, 3, 0, 8'h00, 0, 32'h0,   4'b1111, 0, 0);
    vecs[9]  = mk(0, 1, 8'hA4, 4'b0000, 32'h0,    0,   0, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b1111, 0, 0);
    vecs[10] = mk(0, 0, 8'h00, 4'b0100, 32'h100,  0,   0, 4'b0000, 0, 1, 8'hA2, 2, 32'h102, 4'b1111, 0, 0);
    vecs[11] = mk(0, 0, 8'h00, 4'b0001, 32'h200,  1,   1, 4'b0000, 0, 1, 8'hA0, 0, 32'h200, 4'b1011, 0, 0);
    vecs[12] = mk(0, 0, 8'h00, 4'b1000, 32'h300,  1,   1, 4'b0000, 0, 1, 8'hA3, 3, 32'h303, 4'b1010, 0, 0);
    vecs[13] = mk(0, 0, 8'h00, 4'b0010, 32'h400,  1,   1, 4'b0000, 0, 1, 8'hA1, 1, 32'h401, 4'b0010, 0, 0);
    vecs[14] = mk(0, 0, 8'h00, 4'b0000, 32'h0,    1,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0000, 1, 0);
    vecs[15] = mk(0, 0, 8'h00, 4'b1000, 32'h55,   0,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0000, 1, 1);
    vecs[16] = mk(0, 0, 8'h00, 4'b0000, 32'h0,    0,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0000, 1, 1);
    vecs[17] = mk(0, 1, 8'hB0, 4'b0000, 32'h0,    0,   1, 4'b0001, 0, 0, 8'h00, 0, 32'h0,   4'b0001, 0, 1);
    vecs[18] = mk(0, 1, 8'hB1, 4'b0000, 32'h0,    0,   1, 4'b0010, 1, 0, 8'h00, 0, 32'h0,   4'b0011, 0, 1);
    vecs[19] = mk(1, 1, 8'hB2, 4'b0000, 32'h0,    0,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0000, 1, 0);
    vecs[20] = mk(0, 0, 8'h00, 4'b0000, 32'h0,    0,   1, 4'b0000, 0, 0, 8'h00, 0, 32'h0,   4'b0000, 1, 0);

    for (int i = 0; i < 21; i++) begin
      rst           = vecs[i].rst;
      bus.job_valid = vecs[i].jv;
      bus.job_id    = vecs[i].jid;
      bus.core_done = vecs[i].done;
      set_values(vecs[i].val);
      bus.res_ready = vecs[i].rr;
      tick();
      chk($sformatf("vec%0d", i), {8'd0, observe()}, {8'd0, vecs[i].exp});
    end
    rst           = 1'b0;
    bus.job_valid = 1'b0;
    bus.core_done = '0;
    bus.res_ready = 1'b0;

    // Single job with a 10-cycle run time; rr_ptr starts at 0.
    launch(8'h11, 0);
    tick();
    chk("start_single_cycle", {60'd0, bus.core_start}, 64'd0);
    repeat (9) tick();
    chk("single_running", {63'd0, bus.res_valid}, 64'd0);
    do_done(4'b0001, 32'h7);
    chk("single_result", {bus.res_valid, bus.res_core, bus.res_id, bus.res_value},
        {1'b1, 2'd0, 8'h11, 32'h7});
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("single_idle", {62'd0, bus.idle, bus.res_valid}, {62'd0, 1'b1, 1'b0});

    // Saturation: 4 jobs fill the array, the 5th waits for the first pop (rr_ptr=1).
    for (int i = 1; i <= 4; i++) launch(8'(i), i - 1);
    chk("sat_not_ready", {63'd0, bus.job_ready}, 64'd0);
    bus.job_valid = 1'b1;
    bus.job_id    = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_held_%0d", i), {60'd0, bus.core_start}, 64'd0);
    end
    do_done(4'b0010, 32'h900);
    chk("sat_result", {bus.res_valid, bus.res_core, bus.res_id, bus.res_value},
        {1'b1, 2'd1, 8'd2, 32'h901});
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("sat_pop_no_reuse", {bus.job_ready, bus.core_start}, {1'b1, 4'b0000});
    tick();
    bus.job_valid = 1'b0;
    chk("sat_fifth_launch", {bus.core_start, bus.core_sel}, {4'b0010, 2'd1});
    tag_m[1] = 8'd5;

    // All four finish together with rr_ptr=2: expect 2,3,0,1.
    do_done(4'b1111, 32'h1000);
    burst({4'd1, 4'd0, 4'd3, 4'd2}, 32'h1000);

    // Move rr_ptr to 0 by popping core 3 alone, then all four finish: expect 0,1,2,3.
    for (int i = 0; i < 4; i++) launch(8'h21 + 8'(i), i);
    do_done(4'b1000, 32'h2000);
    chk("rr_setup_result", {bus.res_valid, bus.res_core, bus.res_id, bus.res_value},
        {1'b1, 2'd3, 8'h24, 32'h2003});
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    launch(8'h25, 3);
    do_done(4'b1111, 32'h3000);
    burst({4'd3, 4'd2, 4'd1, 4'd0}, 32'h3000);

    // Backpressure: core 1 result stalls 20 cycles while core 0 (ahead in rr order) finishes.
    launch(8'h31, 0);
    launch(8'h32, 1);
    do_done(4'b0010, 32'h500);
    chk("bp_first", {bus.res_valid, bus.res_core, bus.res_id, bus.res_value},
        {1'b1, 2'd1, 8'h32, 32'h501});
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        bus.core_done = 4'b0001;
        set_values(32'h600);
      end
      tick();
      bus.core_done = '0;
      chk($sformatf("bp_stable_%0d", c), {bus.res_valid, bus.res_core, bus.res_id, bus.res_value},
          {1'b1, 2'd1, 8'h32, 32'h501});
    end
    chk("bp_both_busy", {60'd0, bus.core_busy}, {60'd0, 4'b0011});
    bus.res_ready = 1'b1;
    tick();
    chk("bp_second", {bus.res_valid, bus.res_core, bus.res_id, bus.res_value},
        {1'b1, 2'd0, 8'h31, 32'h600});
    tick();
    bus.res_ready = 1'b0;
    chk("bp_drained", {62'd0, bus.res_valid, bus.idle}, {62'd0, 1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
